// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider.
package div_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/full_adder_pg.sv
// One-bit full adder cell used to build the ripple-chain subtractor.
module full_adder_pg (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    assign sum_o  = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & (a_i ^ b_i));

endmodule

// File: rtl/rc_subtractor_pg.sv
// Ripple-carry subtractor: a - b computed as a + ~b + 1.
module rc_subtractor_pg #(
    parameter int unsigned WIDTH = 5
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b1;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        full_adder_pg u_fa (
            .a_i   (a_i[i]),
            .b_i   (~b_i[i]),
            .cin_i (carry[i]),
            .sum_o (diff_o[i]),
            .cout_o(carry[i+1])
        );
    end

    // A final carry means a >= b, so no borrow was needed.
    assign borrow_o = ~carry[WIDTH];

endmodule

// File: rtl/seq_divider_pg.sv
// Sequential restoring unsigned divider: one quotient bit per cycle,
// fixed latency, divide-by-zero short-circuited straight to DONE.
module seq_divider_pg
    import div_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH:0]   r_q, r_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   trial;
    logic             borrow;

    assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};
    assign q_sh = q_q << 1;

    rc_subtractor_pg #(
        .WIDTH(WIDTH + 1)
    ) u_sub (
        .a_i     (r_sh),
        .b_i     ({1'b0, dvs_q}),
        .diff_o  (trial),
        .borrow_o(borrow)
    );

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        dbz_d   = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    dvs_d = divisor;
                    r_d   = '0;
                    q_d   = dividend;
                    cnt_d = CW'(WIDTH);
                    dbz_d = 1'b0;
                    if (divisor == '0) begin
                        state_d = DONE;
                        quot_d  = '1;
                        rem_d   = dividend;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                q_d    = q_sh;
                q_d[0] = ~borrow;
                r_d    = borrow ? r_sh : trial;
                cnt_d  = cnt_q - CW'(1);
                // Publish on the final iteration so results never show partial state.
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                    quot_d  = q_d;
                    rem_d   = r_d[WIDTH-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_pg.sv
// Directed and exhaustive self-checking bench for seq_divider_pg.
module tb_seq_divider_pg;

    localparam int unsigned W       = 4;
    localparam int          TIMEOUT = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    seq_divider_pg #(
        .WIDTH(W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start = 1'b0;
        sb.push_back(model(a, b));
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < TIMEOUT) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input int lat, input int exp_lat);
        exp_t e;
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_q"}, 32'(quotient), 32'(e.q));
            chk({tag, "_r"}, 32'(remainder), 32'(e.r));
            chk({tag, "_dbz"}, 32'(div_by_zero), 32'(e.dbz));
        end
    endtask

    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b);
        int    lat;
        string tag;
        tag = $sformatf("div_%0d_%0d", a, b);
        do_accept(a, b);
        wait_done(lat);
        check_result(tag, lat, (b == '0) ? 1 : int'(W) + 1);
        if (b != '0) begin
            chk({tag, "_eq"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk({tag, "_rlt"}, 32'(remainder < b), 32'd1);
        end
        tick();
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        int done_cnt;

        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_q", 32'(quotient), 32'd0);
        chk("rst_r", 32'(remainder), 32'd0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst_n = 1'b1;
        tick();

        run_div(4'd13, 4'd4);
        run_div(4'd3, 4'd7);
        run_div(4'd15, 4'd1);
        run_div(4'd9, 4'd0);
        run_div(4'd6, 4'd2);

        // start with new operands while BUSY must be ignored
        do_accept(4'd13, 4'd4);
        start    = 1'b1;
        dividend = 4'd8;
        divisor  = 4'd3;
        busy_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) busy_cnt++;
            if (i == 3) start = 1'b0;
            tick();
        end
        chk("ign_busy_cycles", 32'(busy_cnt), 32'd4);
        check_result("ign", int'(W) + 1, int'(W) + 1);
        tick();
        chk("ign_idle", 32'(busy | done), 32'd0);

        // reset during the second BUSY cycle
        do_accept(4'd13, 4'd4);
        tick();
        chk("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_q", 32'(quotient), 32'd0);
        chk("mid_rst_r", 32'(remainder), 32'd0);
        chk("mid_rst_dbz", 32'(div_by_zero), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) done_cnt++;
            tick();
        end
        chk("mid_rst_no_done", 32'(done_cnt), 32'd0);
        chk("mid_rst_q_hold", 32'(quotient), 32'd0);
        run_div(4'd7, 4'd2);

        // back-to-back: start held in the DONE cycle
        do_accept(4'd13, 4'd4);
        wait_done(lat);
        check_result("b2b_first", lat, int'(W) + 1);
        do_accept(4'd14, 4'd5);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_hold_q", 32'(quotient), 32'd3);
        wait_done(lat);
        check_result("b2b_second", lat, int'(W) + 1);
        tick();

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run_div(W'(a), W'(b));
            end
        end

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
